// File: rtl/oflow_conflict_resolve_par.sv
// Overflow conflict resolver: scans each PE's candidate rows, gives object-ID ownership to the
// lowest score and pushes losers to fallback rows. Optional macro OFLOW_CR_STATS_EN adds conflict_cnt.
module oflow_conflict_resolve_par #(
    parameter int NUM_PE           = 8,
    parameter int NUM_ROWS         = 4,
    parameter int SCORE_W          = 16,
    parameter int ID_W             = 7,
    parameter int MAX_CONFLICTS_TH = 64,
    localparam int PW = (NUM_PE > 1) ? $clog2(NUM_PE) : 1,
    localparam int RW = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1,
    localparam int CW = $clog2(MAX_CONFLICTS_TH + 1)
) (
    input  logic               clk,
    input  logic               reset_N,
    input  logic               start_cr,
    output logic               done_cr,
    output logic               abort_cr,
    input  logic [SCORE_W-1:0] score_to_cr,
    input  logic [ID_W-1:0]    id_to_cr,
    output logic [RW-1:0]      row_sel_from_cr,
    output logic [PW-1:0]      pe_sel_from_cr,
    output logic [RW-1:0]      row_to_change,
    output logic [PW-1:0]      pe_to_change,
    output logic               data_to_score_board,
    output logic               write_to_pointer,
    output logic [NUM_PE-1:0]  unresolved_vec,
`ifdef OFLOW_CR_STATS_EN
    output logic [CW-1:0]      conflict_cnt,
`endif
    output logic [2:0]         o_dbg_state
);

    localparam int DEPTH = 2 ** ID_W;
    localparam logic [PW:0]   IDX_END  = (PW + 1)'(NUM_PE);
    localparam logic [RW-1:0] LAST_ROW = RW'(NUM_ROWS - 1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(MAX_CONFLICTS_TH);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_INIT  = 3'd1,
        S_READ  = 3'd2,
        S_EVAL  = 3'd3,
        S_WRITE = 3'd4,
        S_NEXT  = 3'd5,
        S_DONE  = 3'd6
    } state_t;

    state_t             r_state;
    logic [DEPTH-1:0]   r_valid;
    logic [SCORE_W-1:0] r_tbl_score [DEPTH];
    logic [PW-1:0]      r_tbl_owner [DEPTH];
    logic [RW-1:0]      r_ptr [NUM_PE];
    logic [PW:0]        r_idx;
    logic [PW-1:0]      r_cur_pe;
    logic [PW-1:0]      r_loser;
    logic               r_loser_exh;
    logic [CW-1:0]      r_conflicts;

    logic               w_hit;
    logic               w_steal;
    logic [PW-1:0]      w_loser;
    logic [RW-1:0]      w_loser_ptr;
    logic               w_loser_exh;
    logic [PW:0]        w_idx_next;
    logic [PW-1:0]      w_next_pe;

    // Ties keep the incumbent: only a strictly lower score evicts the stored owner.
    assign w_hit       = r_valid[id_to_cr];
    assign w_steal     = w_hit && (score_to_cr < r_tbl_score[id_to_cr]);
    assign w_loser     = w_steal ? r_tbl_owner[id_to_cr] : r_cur_pe;
    assign w_loser_ptr = r_ptr[w_loser];
    assign w_loser_exh = (w_loser_ptr == LAST_ROW);
    assign w_idx_next  = r_idx + 1'b1;
    assign w_next_pe   = w_idx_next[PW-1:0];
    assign o_dbg_state = r_state;

    always_ff @(posedge clk) begin
        if (r_state == S_EVAL && (!w_hit || w_steal)) begin
            r_tbl_score[id_to_cr] <= score_to_cr;
            r_tbl_owner[id_to_cr] <= r_cur_pe;
        end
    end

    always_ff @(posedge clk or posedge reset_N) begin
        if (reset_N) begin
            r_state             <= S_IDLE;
            r_valid             <= '0;
            for (int p = 0; p < NUM_PE; p++) r_ptr[p] <= '0;
            r_idx               <= '0;
            r_cur_pe            <= '0;
            r_loser             <= '0;
            r_loser_exh         <= 1'b0;
            r_conflicts         <= '0;
            done_cr             <= 1'b0;
            abort_cr            <= 1'b0;
            row_sel_from_cr     <= '0;
            pe_sel_from_cr      <= '0;
            row_to_change       <= '0;
            pe_to_change        <= '0;
            data_to_score_board <= 1'b0;
            write_to_pointer    <= 1'b0;
            unresolved_vec      <= '0;
`ifdef OFLOW_CR_STATS_EN
            conflict_cnt        <= '0;
`endif
        end else begin
            done_cr          <= 1'b0;
            write_to_pointer <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start_cr) begin
                        r_state  <= S_INIT;
                        abort_cr <= 1'b0;
`ifdef OFLOW_CR_STATS_EN
                        conflict_cnt <= '0;
`endif
                    end
                end
                S_INIT: begin
                    r_valid         <= '0;
                    for (int p = 0; p < NUM_PE; p++) r_ptr[p] <= '0;
                    unresolved_vec  <= '0;
                    r_conflicts     <= '0;
                    abort_cr        <= 1'b0;
                    r_idx           <= '0;
                    r_cur_pe        <= '0;
                    pe_sel_from_cr  <= '0;
                    row_sel_from_cr <= '0;
                    r_state         <= S_READ;
                end
                S_READ: r_state <= S_EVAL;
                S_EVAL: begin
                    r_valid[id_to_cr] <= 1'b1;
                    if (!w_hit) begin
                        r_state <= S_NEXT;
                    end else begin
                        // Strobe and pointer update land together so the write is visible during WRITE.
                        r_state          <= S_WRITE;
                        write_to_pointer <= 1'b1;
                        pe_to_change     <= w_loser;
                        r_loser          <= w_loser;
                        r_loser_exh      <= w_loser_exh;
                        r_conflicts      <= r_conflicts + 1'b1;
                        if (!w_loser_exh) begin
                            r_ptr[w_loser]      <= w_loser_ptr + 1'b1;
                            row_to_change       <= w_loser_ptr + 1'b1;
                            data_to_score_board <= 1'b1;
                        end else begin
                            row_to_change           <= w_loser_ptr;
                            data_to_score_board     <= 1'b0;
                            unresolved_vec[w_loser] <= 1'b1;
                        end
                    end
                end
                S_WRITE: begin
                    if (r_conflicts >= CNT_MAX) begin
                        r_state  <= S_DONE;
                        done_cr  <= 1'b1;
                        abort_cr <= 1'b1;
`ifdef OFLOW_CR_STATS_EN
                        conflict_cnt <= r_conflicts;
`endif
                    end else if (!r_loser_exh) begin
                        r_cur_pe        <= r_loser;
                        pe_sel_from_cr  <= r_loser;
                        row_sel_from_cr <= r_ptr[r_loser];
                        r_state         <= S_READ;
                    end else begin
                        r_state <= S_NEXT;
                    end
                end
                S_NEXT: begin
                    r_idx <= w_idx_next;
                    if (w_idx_next == IDX_END) begin
                        r_state <= S_DONE;
                        done_cr <= 1'b1;
`ifdef OFLOW_CR_STATS_EN
                        conflict_cnt <= r_conflicts;
`endif
                    end else begin
                        r_cur_pe        <= w_next_pe;
                        pe_sel_from_cr  <= w_next_pe;
                        row_sel_from_cr <= r_ptr[w_next_pe];
                        r_state         <= S_READ;
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_oflow_conflict_resolve_par.sv
// Directed bench for oflow_conflict_resolve_par: a 4-PE instance for the main scenarios and an
// 8-PE instance with a conflict budget of 2 for the abort path.
module tb_oflow_conflict_resolve_par;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    int   checks = 0;
    int   errors = 0;
    bit   overlap = 1'b0;

    logic [7:0] exp_q[$];
    logic [7:0] act_q[$];
    logic [7:0] rd_q[$];
    logic [7:0] b_act_q[$];

    // Instance A: NUM_PE=4, default budget
    logic        a_start, a_done, a_abort, a_data, a_wr;
    logic [15:0] a_score;
    logic [6:0]  a_id;
    logic [1:0]  a_row_sel, a_pe_sel, a_row_chg, a_pe_chg;
    logic [3:0]  a_unres;
    logic [2:0]  a_state;
    logic [6:0]  a_sb_id [4][4];
    logic [15:0] a_sb_sc [4][4];

    // Instance B: NUM_PE=8, budget of 2
    logic        b_start, b_done, b_abort, b_data, b_wr;
    logic [15:0] b_score;
    logic [6:0]  b_id;
    logic [1:0]  b_row_sel, b_row_chg;
    logic [2:0]  b_pe_sel, b_pe_chg;
    logic [7:0]  b_unres;
    logic [2:0]  b_state;
    logic [6:0]  b_sb_id [8][4];
    logic [15:0] b_sb_sc [8][4];
`ifdef OFLOW_CR_STATS_EN
    logic [6:0]  a_cnt;
    logic [1:0]  b_cnt;
`endif

    assign a_id    = a_sb_id[a_pe_sel][a_row_sel];
    assign a_score = a_sb_sc[a_pe_sel][a_row_sel];
    assign b_id    = b_sb_id[b_pe_sel][b_row_sel];
    assign b_score = b_sb_sc[b_pe_sel][b_row_sel];

    oflow_conflict_resolve_par #(.NUM_PE(4), .NUM_ROWS(4), .SCORE_W(16), .ID_W(7), .MAX_CONFLICTS_TH(64)) u_dut_a (
        .clk(clk), .reset_N(rst), .start_cr(a_start), .done_cr(a_done), .abort_cr(a_abort),
        .score_to_cr(a_score), .id_to_cr(a_id), .row_sel_from_cr(a_row_sel), .pe_sel_from_cr(a_pe_sel),
        .row_to_change(a_row_chg), .pe_to_change(a_pe_chg), .data_to_score_board(a_data),
        .write_to_pointer(a_wr), .unresolved_vec(a_unres),
`ifdef OFLOW_CR_STATS_EN
        .conflict_cnt(a_cnt),
`endif
        .o_dbg_state(a_state)
    );

    oflow_conflict_resolve_par #(.NUM_PE(8), .NUM_ROWS(4), .SCORE_W(16), .ID_W(7), .MAX_CONFLICTS_TH(2)) u_dut_b (
        .clk(clk), .reset_N(rst), .start_cr(b_start), .done_cr(b_done), .abort_cr(b_abort),
        .score_to_cr(b_score), .id_to_cr(b_id), .row_sel_from_cr(b_row_sel), .pe_sel_from_cr(b_pe_sel),
        .row_to_change(b_row_chg), .pe_to_change(b_pe_chg), .data_to_score_board(b_data),
        .write_to_pointer(b_wr), .unresolved_vec(b_unres),
`ifdef OFLOW_CR_STATS_EN
        .conflict_cnt(b_cnt),
`endif
        .o_dbg_state(b_state)
    );

    // Monitor: write strobes as {pe,row,data}, reads as {pe,row}
    always @(negedge clk) begin
        if (!rst) begin
            if (a_wr) act_q.push_back({2'b00, a_pe_chg, 1'b0, a_row_chg, a_data});
            if (a_state == 3'd2) rd_q.push_back({2'b00, a_pe_sel, 2'b00, a_row_sel});
            if (b_wr) b_act_q.push_back({1'b0, b_pe_chg, 1'b0, b_row_chg, b_data});
        end
        if ((a_wr && a_done) || (b_wr && b_done)) overlap = 1'b1;
    end

    task automatic fill_a();
        for (int p = 0; p < 4; p++)
            for (int r = 0; r < 4; r++) begin
                a_sb_id[p][r] = 7'(64 + p * 4 + r);
                a_sb_sc[p][r] = 16'd100;
            end
    endtask

    task automatic fill_b();
        for (int p = 0; p < 8; p++)
            for (int r = 0; r < 4; r++) begin
                b_sb_id[p][r] = 7'(64 + p * 4 + r);
                b_sb_sc[p][r] = 16'd100;
            end
    endtask

    task automatic run_a(output int cyc);
        act_q.delete();
        rd_q.delete();
        exp_q.delete();
        @(negedge clk) a_start = 1'b1;
        @(negedge clk) a_start = 1'b0;
        cyc = 0;
        while (!a_done && cyc < 400) begin
            @(negedge clk);
            cyc++;
        end
        if (cyc >= 400) begin
            checks++; errors++;
            $display("FAIL run_a_timeout: done_cr not seen within %0d cycles", cyc);
        end
    endtask

    task automatic run_b(output int cyc);
        b_act_q.delete();
        exp_q.delete();
        @(negedge clk) b_start = 1'b1;
        @(negedge clk) b_start = 1'b0;
        cyc = 0;
        while (!b_done && cyc < 400) begin
            @(negedge clk);
            cyc++;
        end
        if (cyc >= 400) begin
            checks++; errors++;
            $display("FAIL run_b_timeout: done_cr not seen within %0d cycles", cyc);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({a_done, a_abort, a_row_sel, a_pe_sel, a_row_chg, a_pe_chg, a_data, a_wr, a_unres} !== 18'd0) begin
            errors++;
            $display("FAIL reset_outputs_a: got %b, expected all zero",
                     {a_done, a_abort, a_row_sel, a_pe_sel, a_row_chg, a_pe_chg, a_data, a_wr, a_unres});
        end
        checks++;
        if ({b_done, b_abort, b_wr, b_unres, a_state, b_state} !== 17'd0) begin
            errors++;
            $display("FAIL reset_outputs_b_state: got %b, expected all zero",
                     {b_done, b_abort, b_wr, b_unres, a_state, b_state});
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_distinct();
        int cyc;
        fill_a();
        run_a(cyc);
        checks++;
        if (cyc !== 13) begin errors++; $display("FAIL distinct_latency: got %0d, expected 13", cyc); end
        checks++;
        if (act_q.size() !== 0) begin errors++; $display("FAIL distinct_writes: got %0d, expected 0", act_q.size()); end
        checks++;
        if (a_unres !== 4'b0000) begin errors++; $display("FAIL distinct_unresolved: got %b, expected 0000", a_unres); end
        checks++;
        if (a_abort !== 1'b0) begin errors++; $display("FAIL distinct_abort: got %b, expected 0", a_abort); end
    endtask

    task automatic test_steal();
        int cyc;
        logic [7:0] exp_rd [5];
        fill_a();
        a_sb_id[0][0] = 7'd5; a_sb_sc[0][0] = 16'd10;
        a_sb_id[1][0] = 7'd5; a_sb_sc[1][0] = 16'd3;
        run_a(cyc);
        exp_q.push_back({4'd0, 3'd1, 1'b1});
        exp_rd[0] = {4'd0, 4'd0}; exp_rd[1] = {4'd1, 4'd0}; exp_rd[2] = {4'd0, 4'd1};
        exp_rd[3] = {4'd2, 4'd0}; exp_rd[4] = {4'd3, 4'd0};
        checks++;
        if (cyc !== 16) begin errors++; $display("FAIL steal_latency: got %0d, expected 16", cyc); end
        checks++;
        if (act_q.size() !== 1) begin
            errors++; $display("FAIL steal_write_count: got %0d, expected 1", act_q.size());
        end else if (act_q[0] !== exp_q[0]) begin
            errors++; $display("FAIL steal_write: got %h, expected %h", act_q[0], exp_q[0]);
        end
        checks++;
        if (rd_q.size() !== 5) begin
            errors++; $display("FAIL steal_read_count: got %0d, expected 5", rd_q.size());
        end else begin
            for (int i = 0; i < 5; i++)
                if (rd_q[i] !== exp_rd[i]) begin
                    errors++; $display("FAIL steal_read[%0d]: got %h, expected %h", i, rd_q[i], exp_rd[i]);
                end
        end
        checks++;
        if (a_unres !== 4'b0000) begin errors++; $display("FAIL steal_unresolved: got %b, expected 0000", a_unres); end
    endtask

    task automatic test_tie();
        int cyc;
        fill_a();
        a_sb_id[0][0] = 7'd7; a_sb_sc[0][0] = 16'd9;
        a_sb_id[1][0] = 7'd7; a_sb_sc[1][0] = 16'd9;
        run_a(cyc);
        exp_q.push_back({4'd1, 3'd1, 1'b1});
        checks++;
        if (cyc !== 16) begin errors++; $display("FAIL tie_latency: got %0d, expected 16", cyc); end
        checks++;
        if (act_q.size() !== 1) begin
            errors++; $display("FAIL tie_write_count: got %0d, expected 1", act_q.size());
        end else if (act_q[0] !== exp_q[0]) begin
            errors++; $display("FAIL tie_write: got %h, expected %h", act_q[0], exp_q[0]);
        end
    endtask

    task automatic test_exhaust();
        int cyc;
        fill_a();
        a_sb_id[0][0] = 7'd10; a_sb_sc[0][0] = 16'd1;
        a_sb_id[1][0] = 7'd11; a_sb_sc[1][0] = 16'd1;
        a_sb_id[2][0] = 7'd10; a_sb_sc[2][0] = 16'd5;
        a_sb_id[2][1] = 7'd11; a_sb_sc[2][1] = 16'd5;
        a_sb_id[2][2] = 7'd10; a_sb_sc[2][2] = 16'd5;
        a_sb_id[2][3] = 7'd11; a_sb_sc[2][3] = 16'd5;
        run_a(cyc);
        exp_q.push_back({4'd2, 3'd1, 1'b1});
        exp_q.push_back({4'd2, 3'd2, 1'b1});
        exp_q.push_back({4'd2, 3'd3, 1'b1});
        exp_q.push_back({4'd2, 3'd3, 1'b0});
        checks++;
        if (cyc !== 23) begin errors++; $display("FAIL exhaust_latency: got %0d, expected 23", cyc); end
        checks++;
        if (act_q.size() !== exp_q.size()) begin
            errors++; $display("FAIL exhaust_write_count: got %0d, expected %0d", act_q.size(), exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++)
                if (act_q[i] !== exp_q[i]) begin
                    errors++; $display("FAIL exhaust_write[%0d]: got %h, expected %h", i, act_q[i], exp_q[i]);
                end
        end
        checks++;
        if (a_unres !== 4'b0100) begin errors++; $display("FAIL exhaust_unresolved: got %b, expected 0100", a_unres); end
    endtask

    task automatic test_abort();
        int cyc;
        fill_b();
        for (int p = 0; p < 5; p++) begin
            b_sb_id[p][0] = 7'd50;
            b_sb_sc[p][0] = 16'(5 - p);
        end
        b_sb_id[0][1] = 7'd50; b_sb_sc[0][1] = 16'd5;
        run_b(cyc);
        exp_q.push_back({4'd0, 3'd1, 1'b1});
        exp_q.push_back({4'd0, 3'd2, 1'b1});
        checks++;
        if (cyc !== 10) begin errors++; $display("FAIL abort_latency: got %0d, expected 10", cyc); end
        checks++;
        if (b_abort !== 1'b1) begin errors++; $display("FAIL abort_flag: got %b, expected 1", b_abort); end
        checks++;
        if (b_act_q.size() !== 2) begin
            errors++; $display("FAIL abort_write_count: got %0d, expected 2", b_act_q.size());
        end else begin
            for (int i = 0; i < 2; i++)
                if (b_act_q[i] !== exp_q[i]) begin
                    errors++; $display("FAIL abort_write[%0d]: got %h, expected %h", i, b_act_q[i], exp_q[i]);
                end
        end
`ifdef OFLOW_CR_STATS_EN
        checks++;
        if (b_cnt !== 2'd2) begin errors++; $display("FAIL abort_conflict_cnt: got %0d, expected 2", b_cnt); end
`endif
        @(negedge clk);
        checks++;
        if ({b_done, b_abort} !== 2'b01) begin
            errors++; $display("FAIL abort_hold: got done,abort=%b, expected 01", {b_done, b_abort});
        end
        fill_b();
        run_b(cyc);
        checks++;
        if (cyc !== 25) begin errors++; $display("FAIL abort_rerun_latency: got %0d, expected 25", cyc); end
        checks++;
        if ({b_abort, b_unres} !== 9'd0) begin
            errors++; $display("FAIL abort_rerun_flags: got %b, expected 0", {b_abort, b_unres});
        end
    endtask

    task automatic test_reset_mid();
        int n;
        int cyc;
        fill_a();
        a_sb_id[0][0] = 7'd5; a_sb_sc[0][0] = 16'd10;
        a_sb_id[1][0] = 7'd5; a_sb_sc[1][0] = 16'd3;
        act_q.delete();
        @(negedge clk) a_start = 1'b1;
        @(negedge clk) a_start = 1'b0;
        n = 0;
        while (!(a_state == 3'd3 && a_pe_sel == 2'd1) && n < 50) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 50) begin errors++; $display("FAIL reset_mid_reach_eval: state %0d, expected EVAL of PE1", a_state); end
        rst = 1'b1;
        #1;
        checks++;
        if ({a_state, a_done, a_abort, a_row_sel, a_pe_sel, a_row_chg, a_pe_chg, a_data, a_wr, a_unres} !== 21'd0) begin
            errors++;
            $display("FAIL reset_mid_outputs: got %b, expected all zero",
                     {a_state, a_done, a_abort, a_row_sel, a_pe_sel, a_row_chg, a_pe_chg, a_data, a_wr, a_unres});
        end
        @(negedge clk);
        checks++;
        if ({a_state, a_wr} !== 4'd0 || act_q.size() !== 0) begin
            errors++; $display("FAIL reset_mid_hold: state %0d wr %b writes %0d, expected 0 0 0", a_state, a_wr, act_q.size());
        end
        rst = 1'b0;
        @(negedge clk);
        run_a(cyc);
        exp_q.push_back({4'd0, 3'd1, 1'b1});
        checks++;
        if (cyc !== 16) begin errors++; $display("FAIL reset_mid_rerun_latency: got %0d, expected 16", cyc); end
        checks++;
        if (act_q.size() !== 1) begin
            errors++; $display("FAIL reset_mid_rerun_count: got %0d, expected 1", act_q.size());
        end else if (act_q[0] !== exp_q[0]) begin
            errors++; $display("FAIL reset_mid_rerun_write: got %h, expected %h", act_q[0], exp_q[0]);
        end
    endtask

    task automatic test_exclusive();
        checks++;
        if (overlap !== 1'b0) begin
            errors++; $display("FAIL write_done_exclusive: got overlap=%b, expected 0", overlap);
        end
    endtask

    initial begin
        rst     = 1'b1;
        a_start = 1'b0;
        b_start = 1'b0;
        fill_a();
        fill_b();
        test_reset();
        test_distinct();
        test_steal();
        test_tie();
        test_exhaust();
        test_abort();
        test_reset_mid();
        test_exclusive();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
